jump_target_arbiter: RTL and testbench

- Parametrised successor to the jump-address select mux. Takes SRC_NUM jump-target sources (for example ALU-resolved branch, jump-adder result, exception vector), each with its own valid.
- Picks the highest-priority source and registers the target. Presents it to the PC/fetch unit over a valid/ready redirect handshake.
- Holds the last target in a real register, not an inferred latch. Sits between the EX/ID jump logic and the PC register.

---
 rtl/jump_target_arbiter.sv | 98 +++++++++
 tb/tb_jump_target_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/jump_target_arbiter.sv
// Fixed-priority jump-target arbiter with a registered valid/ready redirect output.
// Optional JUMP_DROP_CNT_EN adds a saturating count of requests dropped while a redirect is pending.
module jump_target_arbiter #(
  parameter int                 ADDR_W   = 16,
  parameter int                 SRC_NUM  = 3,
  parameter int                 SRC_W    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SRC_NUM-1:0]        src_valid,
  input  logic [SRC_NUM*ADDR_W-1:0] src_addr,
  input  logic                      flush,
  input  logic                      redirect_ready,
  output logic                      redirect_valid,
  output logic [ADDR_W-1:0]         redirect_addr,
  output logic [SRC_W-1:0]          redirect_src,
`ifdef JUMP_DROP_CNT_EN
  output logic [7:0]                drop_cnt,
`endif
  output logic                      busy
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              any_req;
  logic [SRC_W-1:0]  win;
  logic [ADDR_W-1:0] win_addr;
  logic              hs, cap, drop;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    any_req  = |src_valid;
    win      = '0;
    win_addr = src_addr[ADDR_W-1:0];
    for (int i = SRC_NUM-1; i >= 0; i--) begin
      if (src_valid[i]) begin
        win      = SRC_W'(i);
        win_addr = src_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign hs = redirect_valid & redirect_ready;

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && any_req) begin
          cap       = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (hs) begin
          if (any_req) cap = 1'b1;
          else         state_nxt = IDLE;
        end else if (any_req) begin
          // An older instruction (lower index) may override the held target.
          if (win < redirect_src) cap  = 1'b1;
          else                    drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      redirect_addr <= RESET_PC;
      redirect_src  <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        redirect_addr <= win_addr;
        redirect_src  <= win;
      end
    end
  end

  assign redirect_valid = (state == PEND);
  assign busy           = (state == PEND);

`ifdef JUMP_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_jump_target_arbiter.sv
// Scoreboard bench for jump_target_arbiter: driver pushes model expectations, monitor compares.
module tb_jump_target_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src_valid;
  logic [47:0] src_addr;
  logic        flush, redirect_ready;
  logic        redirect_valid, busy;
  logic [15:0] redirect_addr;
  logic [1:0]  redirect_src;
`ifdef JUMP_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  jump_target_arbiter #(.ADDR_W(16), .SRC_NUM(3), .SRC_W(2), .RESET_PC(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_addr(src_addr),
    .flush(flush), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .redirect_src(redirect_src),
`ifdef JUMP_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [1:0]  s;
    int          d;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input exp_t e);
    n_chk++;
    if (redirect_valid !== e.v || busy !== e.v || redirect_addr !== e.a || redirect_src !== e.s) begin
      n_fail++;
      $display("FAIL %s: got v=%0b busy=%0b addr=%h src=%0d, want v=%0b addr=%h src=%0d",
               name, redirect_valid, busy, redirect_addr, redirect_src, e.v, e.a, e.s);
    end
`ifdef JUMP_DROP_CNT_EN
    n_chk++;
    if (drop_cnt !== 8'(e.d)) begin
      n_fail++;
      $display("FAIL %s drop_cnt: got %0d want %0d", name, drop_cnt, e.d);
    end
`endif
  endtask

  // Monitor: compares DUT outputs against each expectation the driver has committed.
  always @(negedge clk) begin
    if (q.size() > 0) check("cycle", q.pop_front());
  end

  // Reference model: one clock of the arbiter's rules from the current pending entry.
  task automatic step(input logic [2:0] v, input logic [15:0] a0, a1, a2,
                      input logic rdy, input logic fl);
    exp_t        e;
    int          w;
    logic [15:0] aa[3];
    aa[0] = a0; aa[1] = a1; aa[2] = a2;
    src_valid = v; src_addr = {a2, a1, a0}; redirect_ready = rdy; flush = fl;
    w = -1;
    for (int i = 2; i >= 0; i--) if (v[i]) w = i;
    e = m;
    if (!m.v) begin
      if (!fl && w >= 0) begin e.v = 1'b1; e.a = aa[w]; e.s = 2'(w); end
    end else if (fl) begin
      e.v = 1'b0;
    end else if (rdy) begin
      if (w >= 0) begin e.a = aa[w]; e.s = 2'(w); end
      else e.v = 1'b0;
    end else if (w >= 0) begin
      if (w < int'(m.s)) begin e.a = aa[w]; e.s = 2'(w); end
      else if (m.d < 255) e.d = m.d + 1;
    end
    m = e;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; src_valid = '0; flush = 1'b0; redirect_ready = 1'b0;
    m = '{v: 1'b0, a: 16'h0100, s: 2'd0, d: 0};
    #1;
    check("async_reset", m);
    @(posedge clk);
    q.push_back(m);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int bound;
    rst_n = 1'b0; src_valid = '0; src_addr = '0; flush = 1'b0; redirect_ready = 1'b0;
    m = '{v: 1'b0, a: 16'h0100, s: 2'd0, d: 0};
    repeat (2) @(posedge clk);
    q.push_back(m);
    #1 rst_n = 1'b1;

    // idle hold
    repeat (3) step(3'b000, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
    // basic latency
    step(3'b100, 16'h0, 16'h0, 16'h1234, 1'b1, 1'b0);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    // priority, override, drop
    step(3'b110, 16'h0, 16'h0040, 16'h0080, 1'b0, 1'b0);
    step(3'b001, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0);
    step(3'b010, 16'h0, 16'h0050, 16'h0, 1'b0, 1'b0);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    // reset mid-PEND then idle hold
    do_reset();
    repeat (3) step(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    // back-to-back
    repeat (4) step(3'b100, 16'h0, 16'h0, 16'h2000, 1'b1, 1'b0);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    // flush wins over request
    step(3'b100, 16'h0, 16'h0, 16'h0300, 1'b0, 1'b0);
    step(3'b001, 16'h0555, 16'h0, 16'h0, 1'b0, 1'b1);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    // flush in IDLE ignores request
    step(3'b011, 16'h0777, 16'h0888, 16'h0, 1'b1, 1'b1);
    // drop saturation
    do_reset();
    step(3'b001, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (300) step(3'b001, 16'h0020, 16'h0, 16'h0, 1'b0, 1'b0);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    // randomized traffic
    for (int k = 0; k < 500; k++)
      step(3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0));
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

    bound = 0;
    while (q.size() > 0 && bound < 10) begin @(posedge clk); bound++; end
    @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
